// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer: LFSR operand generator and MISR signature folder for expression self-test.
// Define EXPR_RESP_CAPTURE_EN to add the STREAM state and the rsp_valid/rsp_ready capture stream.
module expr_vector_sequencer #(
    parameter int unsigned SETTLE    = 1,
    parameter logic [59:0] SEED      = 60'h0_F00D_1,
    parameter logic [89:0] MISR_POLY = 90'h47
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] n_vec,
    output logic [59:0] ops,
    input  logic [89:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] vec_cnt,
    output logic [89:0] signature,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [89:0] rsp_data
);

    localparam int unsigned OPS_W = 60;
    localparam int unsigned Y_W   = 90;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SET_W = 4;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [OPS_W-1:0] SEED_EFF  = (SEED == '0) ? OPS_W'(1) : SEED;
    localparam logic [SET_W-1:0] SETTLE_LD = (SETTLE == 0) ? SET_W'(0) : SET_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CAPTURE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OPS_W-1:0]   r_lfsr;
    logic [OPS_W-1:0]   r_ops;
    logic [Y_W-1:0]     r_sig;
    logic [CNT_W-1:0]   r_vec_cnt;
    logic [CNT_W-1:0]   r_n_vec;
    logic [SET_W-1:0]   r_settle_cnt;
    logic               r_busy;
    logic               r_done;

    logic               w_abort;
    logic               w_start_ok;
    logic               w_last;
    logic [OPS_W-1:0]   w_lfsr_nxt;
    logic [Y_W-1:0]     w_misr_nxt;

    assign w_abort    = abort && (r_state != S_IDLE);
    assign w_start_ok = start && !abort;
    assign w_last     = (r_vec_cnt + CNT_W'(1)) == r_n_vec;
    assign w_lfsr_nxt = {r_lfsr[OPS_W-2:0], r_lfsr[59] ^ r_lfsr[58]};
    assign w_misr_nxt = ({r_sig[Y_W-2:0], 1'b0} ^ (r_sig[Y_W-1] ? MISR_POLY : Y_W'(0))) ^ y_in;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = (n_vec == '0) ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_state_nxt = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
`ifdef EXPR_RESP_CAPTURE_EN
                w_state_nxt = S_STREAM;
`else
                w_state_nxt = w_last ? S_DONE : S_DRIVE;
`endif
            end
            S_STREAM: begin
                // vec_cnt was already advanced in CAPTURE.
                if (rsp_ready) begin
                    w_state_nxt = (r_vec_cnt == r_n_vec) ? S_DONE : S_DRIVE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Operand, signature and run-control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr       <= SEED_EFF;
            r_ops        <= '0;
            r_sig        <= '0;
            r_vec_cnt    <= '0;
            r_n_vec      <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            if (!w_abort) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_ok) begin
                            r_n_vec   <= n_vec;
                            r_vec_cnt <= '0;
                            r_sig     <= '0;
                            r_lfsr    <= SEED_EFF;
                        end
                    end
                    S_DRIVE: begin
                        r_ops        <= r_lfsr;
                        r_lfsr       <= w_lfsr_nxt;
                        r_settle_cnt <= SETTLE_LD;
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt != '0) begin
                            r_settle_cnt <= r_settle_cnt - SET_W'(1);
                        end
                    end
                    S_CAPTURE: begin
                        r_sig     <= w_misr_nxt;
                        r_vec_cnt <= r_vec_cnt + CNT_W'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef EXPR_RESP_CAPTURE_EN
    logic           r_rsp_valid;
    logic [Y_W-1:0] r_rsp_data;

    // Response beat: loaded at capture, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= (w_state_nxt == S_STREAM);
            if ((r_state == S_CAPTURE) && !w_abort) begin
                r_rsp_data <= y_in;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
`else
    assign rsp_valid = 1'b0;
    assign rsp_data  = '0;
`endif

    assign ops       = r_ops;
    assign busy      = r_busy;
    assign done      = r_done;
    assign vec_cnt   = r_vec_cnt;
    assign signature = r_sig;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Self-checking bench for expr_vector_sequencer: random runs against a queue-based LFSR/MISR model.
`timescale 1ns/1ps
module tb_expr_vector_sequencer;

    localparam int          SETTLE = 1;
    localparam logic [59:0] SEED   = 60'h0_F00D_1;
    localparam logic [89:0] POLY   = 90'h47;
`ifdef EXPR_RESP_CAPTURE_EN
    localparam int VEC_CYC = 3 + SETTLE;
`else
    localparam int VEC_CYC = 2 + SETTLE;
`endif
    localparam int CAP_OFF = 2 + SETTLE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] n_vec;
    logic [59:0] ops;
    logic [89:0] y_in;
    logic        busy;
    logic        done;
    logic [15:0] vec_cnt;
    logic [89:0] signature;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [89:0] rsp_data;

    logic        y_const;
    logic [89:0] y_mask;

    int checks = 0;
    int errors = 0;

    logic [59:0] m_ops [$];
    logic [89:0] m_sig [$];

    expr_vector_sequencer #(
        .SETTLE   (SETTLE),
        .SEED     (SEED),
        .MISR_POLY(POLY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .n_vec    (n_vec),
        .ops      (ops),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .vec_cnt  (vec_cnt),
        .signature(signature),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the expression instance: a combinational function of the operands.
    assign y_in = y_const ? 90'h1 : ({ops[29:0], ops} ^ y_mask);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [89:0] y_of(input logic [59:0] o);
        if (y_const) return 90'h1;
        return {o[29:0], o} ^ y_mask;
    endfunction

    // Expected operand vectors and signature after each capture for an n-vector run.
    task automatic build_model(input int n);
        logic [59:0] o;
        logic [89:0] s;
        m_ops.delete();
        m_sig.delete();
        o = (SEED == 60'h0) ? 60'h1 : SEED;
        s = '0;
        for (int k = 0; k < n; k++) begin
            m_ops.push_back(o);
            s = ({s[88:0], 1'b0} ^ (s[89] ? POLY : 90'h0)) ^ y_of(o);
            m_sig.push_back(s);
            o = {o[58:0], o[59] ^ o[58]};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        n_vec = n;
        tick();
        start = 1'b0;
        n_vec = 16'($urandom());
    endtask

    task automatic new_mask();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        y_mask = t[89:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ops, busy, done, vec_cnt, signature, rsp_valid, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_values: ops=%h busy=%b done=%b cnt=%0d sig=%h expected all zero",
                     ops, busy, done, vec_cnt, signature);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({ops, busy, done, vec_cnt, signature, rsp_valid, rsp_data} !== '0) begin
                errors++;
                $display("FAIL idle_after_reset cyc%0d: ops=%h busy=%b done=%b sig=%h expected all zero",
                         i, ops, busy, done, signature);
            end
        end
    endtask

    // Run 0 is the constant y=1 case; the rest use random lengths and a random y mapping.
    task automatic test_main_runs();
        for (int r = 0; r < 4; r++) begin
            int n;
            int last;
            y_const = (r == 0);
            new_mask();
            n = (r == 0) ? 4 : int'($urandom_range(40, 1));
            last = n * VEC_CYC + 1;
            build_model(n);
            do_start(16'(n));
            for (int c = 1; c <= last; c++) begin
                if (c >= CAP_OFF && ((c - CAP_OFF) % VEC_CYC) == 0 && ((c - CAP_OFF) / VEC_CYC) < n) begin
                    int k;
                    logic [89:0] exp_sig;
                    k = (c - CAP_OFF) / VEC_CYC;
                    if (k == 0) exp_sig = '0;
                    else exp_sig = m_sig[k-1];
                    checks++;
                    if (ops !== m_ops[k]) begin
                        errors++;
                        $display("FAIL run%0d ops v%0d: got %h expected %h", r, k, ops, m_ops[k]);
                    end
                    checks++;
                    if (vec_cnt !== 16'(k) || signature !== exp_sig) begin
                        errors++;
                        $display("FAIL run%0d capture v%0d: cnt=%0d sig=%h expected cnt=%0d sig=%h",
                                 r, k, vec_cnt, signature, k, exp_sig);
                    end
                end
                checks++;
                if ({busy, done} !== {1'b1, (c == last)}) begin
                    errors++;
                    $display("FAIL run%0d busy_done c%0d: got %b%b expected 1%b", r, c, busy, done, (c == last));
                end
                if (c != last) tick();
            end
            checks++;
            if (vec_cnt !== 16'(n) || signature !== m_sig[n-1]) begin
                errors++;
                $display("FAIL run%0d final: cnt=%0d sig=%h expected cnt=%0d sig=%h",
                         r, vec_cnt, signature, n, m_sig[n-1]);
            end
            if (r == 0) begin
                checks++;
                if (signature !== 90'hF) begin
                    errors++;
                    $display("FAIL const_y_signature: got %h expected %h", signature, 90'hF);
                end
            end
            tick();
            checks++;
            if ({busy, done} !== 2'b00 || signature !== m_sig[n-1] || vec_cnt !== 16'(n)) begin
                errors++;
                $display("FAIL run%0d post_done: busy=%b done=%b sig=%h expected idle with held sig %h",
                         r, busy, done, signature, m_sig[n-1]);
            end
            tick();
        end
    endtask

    task automatic test_zero_vectors();
        logic [59:0] prev_ops;
        prev_ops = ops;
        do_start(16'd0);
        checks++;
        if ({done, busy, signature, vec_cnt, ops} !== {1'b1, 1'b1, 90'h0, 16'h0, prev_ops}) begin
            errors++;
            $display("FAIL zero_run: done=%b busy=%b sig=%h cnt=%0d ops=%h expected 1 1 0 0 %h",
                     done, busy, signature, vec_cnt, ops, prev_ops);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL zero_run_end: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_start_while_busy();
        int c;
        y_const = 1'b0;
        new_mask();
        build_model(5);
        do_start(16'd5);
        c = 1;
        tick(); c++;
        tick(); c++;
        start = 1'b1;
        n_vec = 16'd2;
        tick(); c++;
        start = 1'b0;
        while (done !== 1'b1 && c < 5 * VEC_CYC + 10) begin
            tick();
            c++;
        end
        checks++;
        if (done !== 1'b1 || c !== 5 * VEC_CYC + 1) begin
            errors++;
            $display("FAIL busy_start_done: done=%b at cycle %0d expected done at %0d", done, c, 5 * VEC_CYC + 1);
        end
        checks++;
        if (vec_cnt !== 16'd5 || signature !== m_sig[4]) begin
            errors++;
            $display("FAIL busy_start_result: cnt=%0d sig=%h expected 5 %h", vec_cnt, signature, m_sig[4]);
        end
        tick();
    endtask

    task automatic test_abort();
        int exp_cnt;
        int c;
        y_const = 1'b0;
        new_mask();
        build_model(100);
        do_start(16'd100);
        for (int i = 1; i < 37; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_cnt = (37 - CAP_OFF - 1) / VEC_CYC + 1;
        checks++;
        if ({busy, done} !== 2'b00 || vec_cnt !== 16'(exp_cnt) || signature !== m_sig[exp_cnt-1]) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b cnt=%0d sig=%h expected 0 0 %0d %h",
                     busy, done, vec_cnt, signature, exp_cnt, m_sig[exp_cnt-1]);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({busy, done, rsp_valid} !== 3'b000) begin
                errors++;
                $display("FAIL abort_quiet cyc%0d: busy=%b done=%b valid=%b expected 000", i, busy, done, rsp_valid);
            end
        end
        build_model(3);
        do_start(16'd3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_busy: got %b expected 1", busy);
        end
        c = 1;
        while (done !== 1'b1 && c < 3 * VEC_CYC + 10) begin
            tick();
            c++;
        end
        checks++;
        if (done !== 1'b1 || c !== 3 * VEC_CYC + 1 || vec_cnt !== 16'd3 || signature !== m_sig[2]) begin
            errors++;
            $display("FAIL restart_run: done=%b cyc=%0d cnt=%0d sig=%h expected 1 %0d 3 %h",
                     done, c, vec_cnt, signature, 3 * VEC_CYC + 1, m_sig[2]);
        end
        tick();
    endtask

    task automatic test_abort_start_idle();
        logic [89:0] prev_sig;
        prev_sig = signature;
        start = 1'b1;
        abort = 1'b1;
        n_vec = 16'd5;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        checks++;
        if ({busy, done} !== 2'b00 || signature !== prev_sig) begin
            errors++;
            $display("FAIL abort_start_idle: busy=%b done=%b sig=%h expected 0 0 %h", busy, done, signature, prev_sig);
        end
    endtask

    task automatic test_reset_midrun();
        y_const = 1'b0;
        do_start(16'd10);
        for (int i = 0; i < 7; i++) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ops, busy, done, vec_cnt, signature, rsp_valid, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_midrun: ops=%h busy=%b cnt=%0d sig=%h expected all zero", ops, busy, vec_cnt, signature);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL reset_midrun_idle cyc%0d: busy=%b done=%b expected 0 0", i, busy, done);
            end
        end
    endtask

`ifdef EXPR_RESP_CAPTURE_EN
    task automatic test_stream();
        logic [89:0] exp_y;
        int w;
        y_const = 1'b0;
        new_mask();
        build_model(3);
        rsp_ready = 1'b0;
        do_start(16'd3);
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (rsp_valid !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            exp_y = y_of(m_ops[k]);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_y) begin
                errors++;
                $display("FAIL stream_beat%0d: valid=%b data=%h expected 1 %h", k, rsp_valid, rsp_data, exp_y);
            end
            for (int s = 0; s < 5; s++) begin
                tick();
                checks++;
                if ({rsp_valid, ops, rsp_data, done} !== {1'b1, m_ops[k], exp_y, 1'b0}) begin
                    errors++;
                    $display("FAIL stream_stall%0d_%0d: valid=%b ops=%h data=%h done=%b expected held beat",
                             k, s, rsp_valid, ops, rsp_data, done);
                end
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            checks++;
            if (rsp_valid !== 1'b0 || done !== (k == 2)) begin
                errors++;
                $display("FAIL stream_handshake%0d: valid=%b done=%b expected 0 %b", k, rsp_valid, done, (k == 2));
            end
        end
        checks++;
        if (vec_cnt !== 16'd3 || signature !== m_sig[2]) begin
            errors++;
            $display("FAIL stream_result: cnt=%0d sig=%h expected 3 %h", vec_cnt, signature, m_sig[2]);
        end
        rsp_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        start     = 1'b0;
        abort     = 1'b0;
        n_vec     = '0;
        rsp_ready = 1'b1;
        y_const   = 1'b0;
        y_mask    = '0;
        test_reset();
        test_main_runs();
        test_zero_vectors();
        test_start_while_busy();
        test_abort();
        test_abort_start_idle();
        test_reset_midrun();
`ifdef EXPR_RESP_CAPTURE_EN
        test_stream();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
